spart_echo_top: RTL and testbench
=================================

Name: spart_echo_top

Overview:
- Self-contained serial echo block: one SPART (Special Purpose Asynchronous Receiver/Transmitter) plus an embedded driver FSM.
- The driver programs the SPART baud divisor from br_cfg, waits for each received byte, and retransmits it unchanged on txd.
- Sits between an external RS-232 line (rxd/txd) and board switches; rda and tbr are exported for status LEDs and benches.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; used to compute the baud divisor table.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- rxd  input  1  serial receive line, idle high, asynchronous to clk.
- txd  output  1  serial transmit line, idle high.
- rda  output  1  receive data available (byte held in receive buffer).
- tbr  output  1  transmit buffer ready (transmitter idle, may accept a byte).

Behaviour:
- Reset (rst=0, async): txd=1, rda=0, tbr=1, baud counter=0, divisor=650, driver in CFG_LO, all shift/buffer registers=0.
- Divisor: DB = floor(CLK_HZ/(16*baud)) - 1. At 50 MHz: 00→650, 01→324, 10→161, 11→80.
- Baud generator: a 16-bit down-counter reloads DB and emits a one-clock tick on reaching 0. The period is DB+1 clocks, giving 16 ticks per bit.
- Internal bus between driver and SPART uses 2-bit ioaddr:
  - 00: TX write / RX read.
  - 01: status read, {6'b0, rda, tbr}.
  - 10: DB low byte write.
  - 11: DB high byte write.
  - Writing DB high reloads the counter.
- Receiver:
  - rxd passes through a 2-flop synchronizer.
  - Start is detected on a synchronized high→low transition while idle.
  - The start bit is re-checked at tick 8; if it reads high, the receiver aborts back to idle (glitch rejection).
  - Each subsequent bit is sampled every 16 ticks: 8 data bits LSB first, then the stop bit.
  - Stop=1: byte copied to the receive buffer, rda=1 on the following clock.
  - Stop=0 (framing error): byte discarded, rda unchanged.
  - rda clears in the clock after the driver reads address 00.
  - A new byte completing while rda=1 overwrites the buffer; rda stays 1.
- Transmitter:
  - A write to 00 while tbr=1 loads {1,data,0} into a 10-bit shift register and drops tbr on the next clock.
  - Each bit is held for 16 ticks, LSB first after the start bit.
  - After the stop bit's 16th tick: txd=1, tbr=1.
  - Writes while tbr=0 are ignored.
- Driver FSM, 2-bit state register, encodings fixed:
  - CFG_LO=0: write DB[7:0]; next state CFG_HI.
  - CFG_HI=1: write DB[15:8]; next state RX_WAIT.
  - RX_WAIT=2: poll status each clock. When rda=1, read address 00 and latch the byte into hold register; next state TX_WAIT.
  - TX_WAIT=3: when tbr=1, write hold to 00; next state RX_WAIT.
- br_cfg is registered each clock. Any change forces CFG_LO on the next clock, regardless of state.
  - An in-flight RX byte completes at the old rate.
  - An in-flight TX completes at the new rate once reloaded.
  - A held byte not yet sent is dropped.
- Echo latency: txd start bit falls no later than 4 clocks plus one baud tick after rda rises, provided tbr=1.
- Full-duplex: receiving the next byte while echoing the previous is supported. The receive buffer holds one byte, so a third byte arriving before the echo completes overwrites per the rule above.

Test Plan:
- Reset: hold rst=0 for 2 clocks, with rxd idle → txd=1, tbr=1, rda=0, driver state 0. After release, state reaches 2 within 3 clocks.
- Echo at 4800, br_cfg=00: drive 0x48 ('H') on rxd with 10416-clock bits → rda pulses high, receive buffer=0x48, driver state 2 reads 0x48. txd then emits start, bits 0,0,0,1,0,0,1,0, stop, each 10416 clocks; tbr returns 1.
- Rate change: set br_cfg=11, then send 0x55 with 1296-clock bits → echoed 0x55 with 1296-clock bit period. DB registers read back 80.
- Back-to-back: send 0x41 then 0x42 with no idle gap at 9600 (br_cfg=01, bit period 5200 clocks) → both echoed in order, no drop.
- Framing error: send 0xA5 with stop bit=0 → rda stays 0, txd stays idle. The next good byte 0x3C echoes correctly.
- Reset mid-frame: assert rst during data bit 4 of an RX and during a TX → txd=1 immediately, rda=0, tbr=1. A fresh byte after release echoes correctly.

Source files
------------

// File: rtl/spart_echo_top.sv
// spart_echo_top: SPART serial port plus a driver FSM that programs the baud
// divisor from br_cfg and echoes every received byte back out on txd.
module spart (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] db_rst,
    input  logic [1:0]  ioaddr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        rda,
    output logic        tbr
);
    logic [15:0] db, cnt;
    logic        tick;
    logic [2:0]  rx_s;
    logic        rx_in, rx_fall, rx_busy, rx_done;
    logic [3:0]  rx_tc, rx_bn;
    logic [7:0]  rx_sh, rx_buf;
    logic [9:0]  tx_sh;
    logic        tx_busy;
    logic [3:0]  tx_tc, tx_bn;
    assign tick    = cnt == 16'd0;
    assign rx_in   = rx_s[1];
    assign rx_fall = rx_s[2] & ~rx_s[1];
    assign rx_done = rx_busy && tick && rx_tc == 4'd7 && rx_bn == 4'd9 && rx_in;
    assign tbr     = !tx_busy;
    assign txd     = tx_busy ? tx_sh[0] : 1'b1;
    always_comb
        rdata = ioaddr == 2'b00 ? rx_buf :
                ioaddr == 2'b01 ? {6'b0, rda, tbr} :
                ioaddr == 2'b10 ? db[7:0] : db[15:8];
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            db  <= db_rst;
            cnt <= 16'd0;
        end else begin
            if (io_wr && ioaddr == 2'b10)
                db[7:0] <= wdata;
            if (io_wr && ioaddr == 2'b11) begin
                db[15:8] <= wdata;
                cnt      <= {wdata, db[7:0]};
            end else
                cnt <= tick ? db : cnt - 16'd1;
        end
    // rx_s[2] is the previous synchronized sample, used for start-edge detection
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rx_s    <= 3'b111;
            rx_busy <= 1'b0;
            rx_tc   <= 4'd0;
            rx_bn   <= 4'd0;
            rx_sh   <= 8'h00;
            rx_buf  <= 8'h00;
            rda     <= 1'b0;
        end else begin
            rx_s <= {rx_s[1:0], rxd};
            if (!rx_busy) begin
                if (rx_fall) begin
                    rx_busy <= 1'b1;
                    rx_tc   <= 4'd0;
                    rx_bn   <= 4'd0;
                end
            end else if (tick) begin
                rx_tc <= rx_tc + 4'd1;
                if (rx_tc == 4'd7) begin
                    rx_bn <= rx_bn + 4'd1;
                    if (rx_bn == 4'd0 && rx_in)
                        rx_busy <= 1'b0;
                    if (rx_bn >= 4'd1 && rx_bn <= 4'd8)
                        rx_sh <= {rx_in, rx_sh[7:1]};
                    if (rx_bn == 4'd9) begin
                        rx_busy <= 1'b0;
                        if (rx_in)
                            rx_buf <= rx_sh;
                    end
                end
            end
            rda <= rx_done ? 1'b1 : (io_rd && ioaddr == 2'b00) ? 1'b0 : rda;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            tx_sh   <= 10'd0;
            tx_busy <= 1'b0;
            tx_tc   <= 4'd0;
            tx_bn   <= 4'd0;
        end else if (io_wr && ioaddr == 2'b00 && !tx_busy) begin
            tx_sh   <= {1'b1, wdata, 1'b0};
            tx_busy <= 1'b1;
            tx_tc   <= 4'd0;
            tx_bn   <= 4'd0;
        end else if (tx_busy && tick) begin
            tx_tc <= tx_tc + 4'd1;
            if (tx_tc == 4'd15) begin
                if (tx_bn == 4'd9)
                    tx_busy <= 1'b0;
                else begin
                    tx_sh <= {1'b1, tx_sh[9:1]};
                    tx_bn <= tx_bn + 4'd1;
                end
            end
        end
endmodule

module spart_echo_top #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rxd,
    output logic       txd,
    output logic       rda,
    output logic       tbr
);
    localparam logic [15:0] DB0 = 16'(CLK_HZ / (16 * 4800) - 1);
    localparam logic [15:0] DB1 = 16'(CLK_HZ / (16 * 9600) - 1);
    localparam logic [15:0] DB2 = 16'(CLK_HZ / (16 * 19200) - 1);
    localparam logic [15:0] DB3 = 16'(CLK_HZ / (16 * 38400) - 1);
    typedef enum logic [1:0] {
        CFG_LO  = 2'd0,
        CFG_HI  = 2'd1,
        RX_WAIT = 2'd2,
        TX_WAIT = 2'd3
    } state_t;
    state_t      state, state_d;
    logic [1:0]  br_q, ioaddr;
    logic        chg, io_wr, io_rd;
    logic [7:0]  hold, wdata, rdata;
    logic [15:0] db_sel;
    assign chg    = br_cfg != br_q;
    assign db_sel = br_q == 2'b00 ? DB0 : br_q == 2'b01 ? DB1 : br_q == 2'b10 ? DB2 : DB3;
    spart u_spart (
        .clk    (clk),
        .rst    (rst),
        .db_rst (DB0),
        .ioaddr (ioaddr),
        .io_wr  (io_wr),
        .io_rd  (io_rd),
        .wdata  (wdata),
        .rdata  (rdata),
        .rxd    (rxd),
        .txd    (txd),
        .rda    (rda),
        .tbr    (tbr)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= CFG_LO;
            br_q  <= 2'b00;
            hold  <= 8'h00;
        end else begin
            state <= state_d;
            br_q  <= br_cfg;
            if (state == RX_WAIT && io_rd && ioaddr == 2'b00)
                hold <= rdata;
        end
    // a br_cfg change suppresses bus side effects so no byte is consumed or sent
    always_comb begin
        state_d = state;
        ioaddr  = 2'b01;
        io_wr   = 1'b0;
        io_rd   = 1'b0;
        wdata   = 8'h00;
        case (state)
            CFG_LO: begin
                ioaddr  = 2'b10;
                io_wr   = 1'b1;
                wdata   = db_sel[7:0];
                state_d = CFG_HI;
            end
            CFG_HI: begin
                ioaddr  = 2'b11;
                io_wr   = 1'b1;
                wdata   = db_sel[15:8];
                state_d = RX_WAIT;
            end
            RX_WAIT: begin
                io_rd   = !chg;
                ioaddr  = rda ? 2'b00 : 2'b01;
                state_d = rda ? TX_WAIT : RX_WAIT;
            end
            TX_WAIT: begin
                ioaddr  = 2'b00;
                io_wr   = !chg;
                wdata   = hold;
                state_d = tbr ? RX_WAIT : TX_WAIT;
            end
        endcase
        if (chg)
            state_d = CFG_LO;
    end
endmodule

// File: tb/tb_spart_echo_top.sv
// tb_spart_echo_top: directed echo scenarios at a scaled clock (bit = 640/320/80 clocks).
module tb_spart_echo_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b00;
    logic       rxd = 1'b1;
    logic       txd, rda, tbr;
    int         checks = 0;
    int         errors = 0;

    spart_echo_top #(.CLK_HZ(3_072_000)) dut (
        .clk    (clk),
        .rst    (rst),
        .br_cfg (br_cfg),
        .rxd    (rxd),
        .txd    (txd),
        .rda    (rda),
        .tbr    (tbr)
    );

    always #5 clk = ~clk;

    task automatic send_bits(input logic [7:0] d, input logic stop, input int bit_clk, input int nbits);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rxd = f[i];
            repeat (bit_clk) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic expect_tx(input logic [7:0] d, input int bit_clk, input string tag);
        logic [9:0] f;
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 40 * bit_clk) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL %s tx_start: txd=%b after %0d clocks, required 0", tag, txd, n);
        end else begin
            repeat (bit_clk / 2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                f[i] = txd;
                if (i < 9) repeat (bit_clk) @(negedge clk);
            end
            checks++;
            if (f !== {1'b1, d, 1'b0}) begin
                errors++;
                $display("FAIL %s tx_frame: got %h required %h", tag, f, {1'b1, d, 1'b0});
            end
        end
    endtask

    task automatic echo(input logic [7:0] d, input int bit_clk, input string tag);
        int n;
        fork
            send_bits(d, 1'b1, bit_clk, 10);
            begin
                n = 0;
                while (rda !== 1'b1 && n < 12 * bit_clk) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (rda !== 1'b1) begin
                    errors++;
                    $display("FAIL %s rda_rise: rda=%b, required 1", tag, rda);
                end else begin
                    checks++;
                    if (dut.u_spart.rx_buf !== d) begin
                        errors++;
                        $display("FAIL %s rx_buf: got %h required %h", tag, dut.u_spart.rx_buf, d);
                    end
                end
                expect_tx(d, bit_clk, tag);
            end
        join
        n = 0;
        while (tbr !== 1'b1 && n < 2 * bit_clk) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tbr !== 1'b1) begin
            errors++;
            $display("FAIL %s tbr_return: tbr=%b, required 1", tag, tbr);
        end
    endtask

    task automatic test_reset;
        rxd = 1'b1;
        br_cfg = 2'b00;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", txd); end
        checks++;
        if (tbr !== 1'b1) begin errors++; $display("FAIL reset_tbr: got %b required 1", tbr); end
        checks++;
        if (rda !== 1'b0) begin errors++; $display("FAIL reset_rda: got %b required 0", rda); end
        checks++;
        if (dut.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", dut.state); end
        checks++;
        if (dut.u_spart.db !== 16'd39) begin errors++; $display("FAIL reset_db: got %0d required 39", dut.u_spart.db); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.state !== 2'd2) begin errors++; $display("FAIL reset_to_rx_wait: got %0d required 2", dut.state); end
    endtask

    task automatic test_echo_4800;
        echo(8'h48, 640, "echo_4800");
    endtask

    task automatic test_rate_change;
        br_cfg = 2'b11;
        repeat (6) @(negedge clk);
        checks++;
        if (dut.u_spart.db !== 16'd4) begin errors++; $display("FAIL rate_db: got %0d required 4", dut.u_spart.db); end
        checks++;
        if (dut.state !== 2'd2) begin errors++; $display("FAIL rate_state: got %0d required 2", dut.state); end
        echo(8'h55, 80, "echo_38400");
    endtask

    task automatic test_back_to_back;
        br_cfg = 2'b01;
        repeat (6) @(negedge clk);
        checks++;
        if (dut.u_spart.db !== 16'd19) begin errors++; $display("FAIL b2b_db: got %0d required 19", dut.u_spart.db); end
        fork
            begin
                send_bits(8'h41, 1'b1, 320, 10);
                send_bits(8'h42, 1'b1, 320, 10);
            end
            begin
                expect_tx(8'h41, 320, "b2b_first");
                expect_tx(8'h42, 320, "b2b_second");
            end
        join
        repeat (640) @(negedge clk);
    endtask

    task automatic test_framing;
        int bad_rda, bad_tx;
        bad_rda = 0;
        bad_tx = 0;
        fork
            send_bits(8'hA5, 1'b0, 320, 10);
            for (int i = 0; i < 3840; i++) begin
                @(negedge clk);
                if (rda !== 1'b0) bad_rda++;
                if (txd !== 1'b1) bad_tx++;
            end
        join
        checks++;
        if (bad_rda != 0) begin errors++; $display("FAIL framing_rda: rda high %0d clocks, required 0", bad_rda); end
        checks++;
        if (bad_tx != 0) begin errors++; $display("FAIL framing_txd: txd low %0d clocks, required 0", bad_tx); end
        echo(8'h3C, 320, "after_framing");
    endtask

    task automatic test_reset_mid;
        int n;
        send_bits(8'h77, 1'b1, 320, 5);
        repeat (160) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || rda !== 1'b0 || tbr !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_rx: txd/rda/tbr=%b%b%b required 101", txd, rda, tbr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (dut.u_spart.db !== 16'd19) begin errors++; $display("FAIL reset_mid_db: got %0d required 19", dut.u_spart.db); end
        fork
            send_bits(8'h5A, 1'b1, 320, 10);
            begin
                n = 0;
                while (txd !== 1'b0 && n < 6000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (3 * 320) @(negedge clk);
            end
        join
        checks++;
        if (tbr !== 1'b0) begin errors++; $display("FAIL reset_mid_tx_busy: tbr=%b required 0", tbr); end
        rst = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1 || rda !== 1'b0 || tbr !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tx: txd/rda/tbr=%b%b%b required 101", txd, rda, tbr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        echo(8'h81, 320, "after_reset");
    endtask

    initial begin
        test_reset();
        test_echo_4800();
        test_rate_change();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
